// File: rtl/fp_pkg.sv
// fp_pkg: shared word and tag types for the FP adder issue arbiter
package fp_pkg;
    typedef logic [31:0] fp_word_t;

    localparam int TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] index;
    } fp_tag_t;

    function automatic logic [TAG_IDX_W-1:0] onehot_idx(input logic [7:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) onehot_idx = TAG_IDX_W'(i);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts after the last granted requester
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] eligible,
    output logic [NUM_REQ-1:0] grant
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] last_grant, next_grant, idx;

    // Walk from the farthest candidate back to the nearest so the nearest eligible one wins
    always_comb begin
        grant = '0;
        next_grant = last_grant;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (eligible[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
                next_grant = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) last_grant <= IW'(NUM_REQ - 1);
        else if (|grant) last_grant <= next_grant;
endmodule

// File: rtl/fp_adder_issue_arbiter.sv
// fp_adder_issue_arbiter: shares one fixed-latency FP adder between NUM_REQ requesters.
// Define FP_ADDER_ARB_FLUSH_EN to add the flush port that kills all in-flight operations.
module fp_adder_issue_arbiter import fp_pkg::*; #(
    parameter int NUM_REQ         = 4,
    parameter int PIPE_LATENCY    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_operand1,
    input  logic [NUM_REQ*32-1:0]  req_operand2,
    output logic                   pipe_valid,
    output logic [31:0]            pipe_operand1,
    output logic [31:0]            pipe_operand2,
    input  logic [31:0]            pipe_result,
    output logic [NUM_REQ-1:0]     result_valid,
    output logic [31:0]            result_data
`ifdef FP_ADDER_ARB_FLUSH_EN
    ,
    input  logic                   flush
`endif
);
    logic                      kill;
    logic [NUM_REQ-1:0]        eligible, grant, result_valid_q;
    logic [TAG_IDX_W-1:0]      grant_idx;
    fp_word_t                  grant_op1, grant_op2;
    fp_tag_t                   new_tag;
    fp_tag_t [PIPE_LATENCY:0]  tags;

`ifdef FP_ADDER_ARB_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req_ready    = grant;
    assign grant_idx    = onehot_idx(8'(grant));
    assign grant_op1    = req_operand1[grant_idx*32 +: 32];
    assign grant_op2    = req_operand2[grant_idx*32 +: 32];
    assign new_tag      = '{valid: |grant, index: grant_idx};
    assign result_valid = kill ? '0 : result_valid_q;

    // A result returning this cycle frees its slot now, so streaming never bubbles
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [2:0] cnt;
        assign eligible[g] = req_valid[g] && !kill && !reset &&
                             (cnt - 3'(result_valid_q[g])) < 3'(MAX_OUTSTANDING);
        always_ff @(posedge clk or posedge reset)
            if (reset) cnt <= '0;
            else if (kill) cnt <= '0;
            else if (grant[g] && !result_valid_q[g]) cnt <= cnt + 3'd1;
            else if (!grant[g] && result_valid_q[g]) cnt <= cnt - 3'd1;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pipe_valid     <= 1'b0;
            pipe_operand1  <= '0;
            pipe_operand2  <= '0;
            tags           <= '0;
            result_valid_q <= '0;
            result_data    <= '0;
        end else begin
            pipe_valid <= |grant;
            if (|grant) begin
                pipe_operand1 <= grant_op1;
                pipe_operand2 <= grant_op2;
            end
            tags <= kill ? '0 : {tags[PIPE_LATENCY-1:0], new_tag};
            result_valid_q <= (tags[PIPE_LATENCY].valid && !kill) ?
                              NUM_REQ'(1) << tags[PIPE_LATENCY].index : '0;
            if (tags[PIPE_LATENCY].valid && !kill) result_data <= pipe_result;
        end
endmodule

// File: tb/tb_fp_adder_issue_arbiter.sv
// tb_fp_adder_issue_arbiter: randomized scoreboard bench with a queue-based reference model
`timescale 1ns/1ps
module tb_fp_adder_issue_arbiter;
    localparam int N = 4, L = 4, MAX = 2;

    logic            clk = 1'b0, reset = 1'b1, flush = 1'b0, hold_ops = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready, result_valid;
    logic [N*32-1:0] op1 = '0, op2 = '0;
    logic            pipe_valid;
    logic [31:0]     pipe_operand1, pipe_operand2, pipe_result, result_data;
    logic [31:0]     stage [L];
    int              cyc = 0, n_cmp = 0, n_bad = 0, last_m = N - 1;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
    } item_t;

    item_t pq[$], rq[$];
    item_t mon_it;

    fp_adder_issue_arbiter #(.NUM_REQ(N), .PIPE_LATENCY(L), .MAX_OUTSTANDING(MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_operand1  (op1),
        .req_operand2  (op2),
        .pipe_valid    (pipe_valid),
        .pipe_operand1 (pipe_operand1),
        .pipe_operand2 (pipe_operand2),
        .pipe_result   (pipe_result),
        .result_valid  (result_valid),
        .result_data   (result_data)
`ifdef FP_ADDER_ARB_FLUSH_EN
        ,
        .flush         (flush)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder: integer sum of the issued operands, L cycles after pipe_valid
    always @(posedge clk) begin
        stage[0] <= pipe_operand1 + pipe_operand2;
        for (int k = 1; k < L; k++) stage[k] <= stage[k-1];
    end
    assign pipe_result = stage[L-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit rnd_flush();
`ifdef FP_ADDER_ARB_FLUSH_EN
        return $urandom_range(0, 30) == 0;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pops the scoreboard whenever an issue or a result is due
    always @(negedge clk) begin
        if (!reset) begin
            if (flush) begin
                chk("flush_result_valid", 32'(result_valid), 32'd0);
                pq.delete();
                rq.delete();
            end else begin
                if (pq.size() != 0 && pq[0].due <= cyc) begin
                    mon_it = pq.pop_front();
                    chk("pipe_valid", 32'(pipe_valid), 32'd1);
                    chk("pipe_operand1", pipe_operand1, mon_it.a);
                    chk("pipe_operand2", pipe_operand2, mon_it.b);
                end else
                    chk("pipe_valid_idle", 32'(pipe_valid), 32'd0);
                if (rq.size() != 0 && rq[0].due <= cyc) begin
                    mon_it = rq.pop_front();
                    chk("result_valid", 32'(result_valid), 32'(1 << mon_it.idx));
                    chk("result_data", result_data, mon_it.a + mon_it.b);
                end else
                    chk("result_valid_idle", 32'(result_valid), 32'd0);
            end
        end
    end

    // One cycle of stimulus followed by the reference model's grant prediction
    task automatic step(input logic [N-1:0] v, input bit rst, input bit fl);
        logic [N-1:0] exp_rdy;
        int cnt, i;
        item_t it;
        @(posedge clk);
        #1;
        reset = rst;
        flush = fl;
        req_valid = v;
        if (!hold_ops)
            for (int r = 0; r < N; r++) begin
                op1[r*32 +: 32] = $urandom;
                op2[r*32 +: 32] = $urandom;
            end
        @(negedge clk);
        exp_rdy = '0;
        if (reset) begin
            chk("reset_pipe_valid", 32'(pipe_valid), 32'd0);
            chk("reset_result_valid", 32'(result_valid), 32'd0);
            chk("reset_result_data", result_data, 32'd0);
            chk("reset_pipe_operand1", pipe_operand1, 32'd0);
            chk("reset_pipe_operand2", pipe_operand2, 32'd0);
            pq.delete();
            rq.delete();
            last_m = N - 1;
        end else if (!flush) begin
            for (int k = 1; k <= N && exp_rdy == '0; k++) begin
                i = (last_m + k) % N;
                cnt = 0;
                foreach (rq[j]) if (rq[j].idx == i && rq[j].due > cyc) cnt++;
                if (v[i] && cnt < MAX) exp_rdy[i] = 1'b1;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        for (int r = 0; r < N; r++)
            if (exp_rdy[r]) begin
                it.idx = r;
                it.a = op1[r*32 +: 32];
                it.b = op2[r*32 +: 32];
                it.due = cyc + 1;
                pq.push_back(it);
                it.due = cyc + L + 2;
                rq.push_back(it);
                last_m = r;
            end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) step('1, 1'b1, 1'b0);
        hold_ops = 1'b1;
        op1[31:0] = 32'h3F80_0000;
        op2[31:0] = 32'h4000_0000;
        step(4'b0001, 1'b0, 1'b0);
        hold_ops = 1'b0;
        repeat (8) step('0, 1'b0, 1'b0);
        repeat (40) step('1, 1'b0, 1'b0);
        repeat (12) step('0, 1'b0, 1'b0);
        repeat (30) step(4'b0100, 1'b0, 1'b0);
        repeat (300) step(4'($urandom), 1'b0, rnd_flush());
        repeat (3) step('1, 1'b0, 1'b0);
        step('1, 1'b1, 1'b0);
        repeat (10) step('1, 1'b0, 1'b0);
        repeat (300) step(4'($urandom), 1'b0, rnd_flush());
        repeat (L + 6) step('0, 1'b0, 1'b0);
        chk("drain_pending", 32'(pq.size() + rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
